// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 8x oversampled UART byte receiver with majority vote, framing check and idle flag.
// Optional even-parity bit is compiled in when UART_RX_PARITY_EN is defined (11-bit frame instead of 8N1).
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 8,
    parameter int IDLE_BITS  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_err,
    output logic       RxD_idle
);

    localparam int DIV      = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PH_W     = $clog2(OVERSAMPLE);
    localparam int IDLE_MAX = IDLE_BITS * OVERSAMPLE;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);
    localparam logic [PH_W-1:0] DECIDE_PH = PH_W'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_e;

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              tick, tick_q;
    logic              sync1_q, rxs_q;
    logic [2:0]        smp_q, smp_d;
    logic              maj, decide;
    logic [PH_W-1:0]   phase_q, phase_d;
    state_e            state_q, state_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [7:0]        data_q, data_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              idle_sat;
`ifdef UART_RX_PARITY_EN
    logic              par_ok_q, par_ok_d;
`endif

    // Free-running: never re-aligned to the line, so start detection carries up to one tick of jitter.
    assign tick      = (div_cnt_q == DIV_W'(DIV - 1));
    assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

    assign smp_d = tick ? {smp_q[1:0], rxs_q} : smp_q;
    assign maj   = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

    // Evaluated the clock after the tick so smp_q already holds the newest sample.
    assign decide = tick_q && (phase_q == DECIDE_PH);

    assign idle_sat = (idle_cnt_q == IDLE_W'(IDLE_MAX));

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_d  = par_ok_q;
`endif
        if (tick && state_q != S_IDLE) begin
            phase_d = phase_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (tick && !rxs_q) begin
                    state_d = S_START;
                    phase_d = '0;
                end
            end
            S_START: begin
                if (decide) begin
                    if (maj) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (decide) begin
                    shreg_d   = {maj, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (decide) begin
                    par_ok_d = ~((^shreg_q) ^ maj);
                    state_d  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (decide) begin
                    if (maj) begin
`ifdef UART_RX_PARITY_EN
                        if (par_ok_q) begin
                            data_d  = shreg_q;
                            ready_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
`else
                        data_d  = shreg_q;
                        ready_d = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (tick_q && maj) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_q != S_IDLE) begin
            idle_cnt_d = '0;
        end else if (tick) begin
            if (!rxs_q) begin
                idle_cnt_d = '0;
            end else if (!idle_sat) begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            tick_q     <= 1'b0;
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            smp_q      <= 3'b111;
            phase_q    <= '0;
            state_q    <= S_IDLE;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'h00;
            data_q     <= 8'h00;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            idle_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_ok_q   <= 1'b0;
`endif
        end else begin
            div_cnt_q  <= div_cnt_d;
            tick_q     <= tick;
            sync1_q    <= RxD;
            rxs_q      <= sync1_q;
            smp_q      <= smp_d;
            phase_q    <= phase_d;
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            idle_cnt_q <= idle_cnt_d;
`ifdef UART_RX_PARITY_EN
            par_ok_q   <= par_ok_d;
`endif
        end
    end

    assign RxD_data       = data_q;
    assign RxD_data_ready = ready_q;
    assign RxD_frame_err  = err_q;
    assign RxD_idle       = idle_sat;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - scoreboard bench for uart_rx_oversampled at default parameters.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

    localparam int BIT = 216;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic [7:0] data;
    logic       ready;
    logic       ferr;
    logic       idle;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         rdy_cyc[$];
    logic [7:0] last_good = 8'h00;
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    always #20 clk = ~clk;

    uart_rx_oversampled dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RxD            (rxd),
        .RxD_data       (data),
        .RxD_data_ready (ready),
        .RxD_frame_err  (ferr),
        .RxD_idle       (idle)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic void expect_byte(input logic [7:0] b);
        exp_q.push_back('{1'b0, b});
        last_good = b;
    endfunction

    function automatic void expect_err();
        exp_q.push_back('{1'b1, last_good});
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ready || ferr) begin
            ev_t e;
            check("strobe_exclusive", {31'd0, ready & ferr}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, ready, ferr}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind_is_err", {31'd0, ferr}, {31'd0, e.is_err});
                check("strobe_data", {24'd0, data}, {24'd0, e.data});
            end
            if (ready) rdy_cyc.push_back(cyc);
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Data bits onward; glitch_bit places a one-tick low pulse mid-way through that (high) bit.
    task automatic send_tail(input logic [7:0] b, input int glitch_bit, input logic stop_val, input int stop_len);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            if (i == glitch_bit) begin
                tick_n(BIT / 2 - 13);
                rxd = 1'b0;
                tick_n(27);
                rxd = b[i];
                tick_n(BIT - (BIT / 2 - 13) - 27);
            end else begin
                tick_n(BIT);
            end
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        tick_n(BIT);
`endif
        rxd = stop_val;
        tick_n(stop_len * BIT);
        rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int glitch_bit, input logic stop_val, input int stop_len);
        rxd = 1'b0;
        tick_n(BIT);
        send_tail(b, glitch_bit, stop_val, stop_len);
    endtask

    initial begin
        int n0;
        int gap;
        logic [7:0] b7e;
        rst_n = 1'b0;
        rxd   = 1'b1;
        tick_n(3);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_ferr", {31'd0, ferr}, 32'd0);
        check("reset_idle", {31'd0, idle}, 32'd0);
        rst_n = 1'b1;
        tick_n(4 * BIT);

        expect_byte(8'h55);
        send_frame(8'h55, -1, 1'b1, 1);
        tick_n(2 * BIT);

        n0 = rdy_cyc.size();
        expect_byte(8'h00);
        expect_byte(8'hFF);
        send_frame(8'h00, -1, 1'b1, 1);
        send_frame(8'hFF, -1, 1'b1, 1);
        tick_n(2 * BIT);
        check("b2b_ready_count", rdy_cyc.size() - n0, 32'd2);
        if (rdy_cyc.size() - n0 == 2) begin
            gap = rdy_cyc[n0 + 1] - rdy_cyc[n0];
            checks++;
            if (gap < FRAME_BITS * BIT - 27 || gap > FRAME_BITS * BIT + 27) begin
                errors++;
                $display("FAIL b2b_gap: got %0d clk expected %0d +-27", gap, FRAME_BITS * BIT);
            end
        end

        rxd = 1'b0;
        tick_n(40);
        rxd = 1'b1;
        tick_n(3 * BIT);

        expect_byte(8'hA3);
        send_frame(8'hA3, 0, 1'b1, 1);
        tick_n(2 * BIT);

        expect_err();
        send_frame(8'h3C, -1, 1'b0, 3);
        tick_n(2 * BIT);
        check("data_kept_after_ferr", {24'd0, data}, 32'hA3);

        expect_byte(8'h81);
        send_frame(8'h81, -1, 1'b1, 1);
        tick_n(2 * BIT);

        // The transmitter is reset alongside the receiver, so the line returns high.
        b7e = 8'h7E;
        rxd = 1'b0;
        tick_n(BIT);
        for (int i = 0; i < 4; i++) begin
            rxd = b7e[i];
            tick_n(BIT);
        end
        rxd = b7e[4];
        tick_n(BIT / 2);
        rst_n = 1'b0;
        #1;
        check("midreset_data", {24'd0, data}, 32'h00);
        check("midreset_ready", {31'd0, ready}, 32'd0);
        check("midreset_ferr", {31'd0, ferr}, 32'd0);
        check("midreset_idle", {31'd0, idle}, 32'd0);
        tick_n(5);
        rst_n = 1'b1;
        rxd   = 1'b1;
        last_good = 8'h00;
        tick_n(6 * BIT);
        check("data_after_aborted_frame", {24'd0, data}, 32'h00);

        expect_byte(8'h12);
        send_frame(8'h12, -1, 1'b1, 1);
        tick_n(15 * BIT);
        check("idle_not_yet", {31'd0, idle}, 32'd0);
        tick_n(2 * BIT);
        check("idle_after_16_bits", {31'd0, idle}, 32'd1);

        expect_byte(8'h5A);
        rxd = 1'b0;
        tick_n(BIT / 2);
        check("idle_drops_on_start", {31'd0, idle}, 32'd0);
        tick_n(BIT - BIT / 2);
        send_tail(8'h5A, -1, 1'b1, 1);
        tick_n(2 * BIT);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        expect_err();
        send_frame(8'h07, -1, 1'b1, 1);
        tick_n(2 * BIT);
        check("data_kept_after_parity_err", {24'd0, data}, 32'h5A);
        par_flip = 1'b0;
        expect_byte(8'h07);
        send_frame(8'h07, -1, 1'b1, 1);
        tick_n(2 * BIT);
`endif

        check("pending_expected_strobes", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- Serial byte receiver placed directly upstream of the servo pulse generator.
- Converts the asynchronous RxD line into 8-bit bytes, each with a one-cycle ready strobe; the servo stage latches the byte on that strobe.
- Adds input synchronisation, 8x oversampling with majority vote, false-start rejection, framing-error detection and an idle-gap indicator.
- Runs on the same 25 MHz system clock as the servo stage.

Parameters:
- CLK_FREQ, 25000000: system clock frequency in Hz.
- BAUD, 115200: serial bit rate.
- OVERSAMPLE, 8: sample ticks per bit; must be a power of two, minimum 4.
- IDLE_BITS, 16: number of bit times the line must stay high before rx_idle asserts.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- RxD  input  1  raw serial line, idle high, asynchronous to clk.
- RxD_data  output  8  last correctly received byte.
- RxD_data_ready  output  1  one-cycle pulse; RxD_data is valid in the same cycle.
- RxD_frame_err  output  1  one-cycle pulse on a bad stop bit.
- RxD_idle  output  1  high while the line has been idle for IDLE_BITS bit times.

Behaviour:
- Reset:
  - Interface: asynchronous, active-low, as already decided.
  - Output values: RxD_data=0x00, RxD_data_ready=0, RxD_frame_err=0, RxD_idle=0.
  - Internal state: synchroniser flops=1, FSM=IDLE, all counters=0.
  - Reset asserted mid-frame aborts the frame; no strobe is produced.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated (27 at the defaults); bit period = DIV*OVERSAMPLE clocks.
  - A free-running counter counts 0..DIV-1 and pulses tick for one clk when it wraps.
  - The counter is never restarted by line activity.
- Input path:
  - 2-flop synchroniser to rxs.
  - A 3-bit shift register loads rxs on each tick; maj = majority of its 3 bits.
- Sub-bit counter: phase counts 0..OVERSAMPLE-1 on ticks. The bit decision is taken from maj when phase == OVERSAMPLE/2+1, i.e. the majority over sample ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- FSM states and transitions:
  - IDLE: on a tick where rxs==0, set phase=0 and go to START.
  - START: at the decision point, maj==1 means a false start; return to IDLE with no output. maj==0 goes to DATA with bit index 0.
  - DATA: at each decision point, shift maj into the shift register LSB-first. After bit 7, go to STOP (or PARITY when the optional feature is enabled).
  - STOP, maj==1 at the decision point:
    - RxD_data takes the shift register on that clock.
    - RxD_data_ready pulses for exactly 1 clk.
    - FSM returns to IDLE.
    - Decision is at mid-stop-bit, so a back-to-back start edge is still detected.
  - STOP, maj==0 at the decision point:
    - RxD_frame_err pulses for 1 clk; RxD_data is unchanged and there is no ready pulse.
    - FSM goes to BREAK.
  - BREAK: wait until maj==1, then go to IDLE. A held-low line (break) produces exactly one frame_err.
- Strobe rules: RxD_data_ready and RxD_frame_err are never high in the same cycle, and each is at most 1 clk per frame.
- Latency: from the RxD falling edge of the start bit to ready is about 9.5 bit periods, plus 2 synchroniser clocks, plus up to 1 tick of quantisation.
- Idle gap counter:
  - Counts ticks while FSM==IDLE and rxs==1; it is cleared by any low sample or by leaving IDLE.
  - It saturates at IDLE_BITS*OVERSAMPLE; RxD_idle=1 while saturated.
  - RxD_idle drops in the cycle after the FSM leaves IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state follows bit 7 and samples one even-parity bit.
  - A mismatch pulses RxD_frame_err instead of RxD_data_ready at the stop-bit decision, and RxD_data is not updated.
  - The frame is 11 bits.
- When undefined: no PARITY state and a 10-bit frame (8N1); the behaviour is exactly as described in Behaviour.

Test Plan:
- Framing: defaults (bit period 216 clk); send 8N1 0x55.
  -> One RxD_data_ready pulse, RxD_data=0x55, RxD_frame_err never high.
- Back-to-back: send 0x00 then 0xFF with no idle gap.
  -> Two ready pulses, data 0x00 then 0xFF.
  -> The ready pulses are 10 bit periods apart, ±1 tick.
- Glitch rejection: 40-clk low glitch on an idle line, and separately a single-tick low mid-data-bit inside a frame 0xA3.
  -> No start is detected for the glitch; the 0xA3 frame is received intact.
- Framing error: send 0x3C with the stop bit held low for 3 bit times, then release.
  -> Exactly one frame_err pulse, no ready pulse, RxD_data retains its previous value.
  -> The following 0x81 is received correctly.
- Reset mid-frame: assert rst_n=0 for 5 clk during bit 4 of 0x7E.
  -> Outputs return to reset values immediately and no ready pulse is produced for that frame.
  -> The next 0x12 is received.
- Idle indicator and parity: after 0x12, hold the line high for 16 bit periods.
  -> RxD_idle=1.
- Parity (UART_RX_PARITY_EN defined): send 0x07 with parity=0.
  -> frame_err pulse.
- Parity (UART_RX_PARITY_EN defined): send 0x07 with parity=1.
  -> ready pulse, RxD_data=0x07.
